// File: rtl/matrix_pkg.sv
// Shared sizes and types for the 5x7 LED matrix scan path.
package matrix_pkg;

    localparam int unsigned NUM_COLS  = 5;
    localparam int unsigned NUM_ROWS  = 7;
    localparam int unsigned COL_IDX_W = $clog2(NUM_COLS);

    typedef logic [NUM_ROWS-1:0]  col_pattern_t;
    typedef logic [COL_IDX_W-1:0] col_idx_t;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;

    localparam col_idx_t LAST_COL = col_idx_t'(NUM_COLS - 1);

    function automatic logic [NUM_COLS-1:0] col_onehot(input col_idx_t idx);
        return NUM_COLS'(1) << idx;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Per-column slot counter: strobes the last blank cycle and the last cycle of the slot.
module scan_timer #(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable_i,
    input  logic run_i,
    output logic blank_done_o,
    output logic slot_done_o
);

    localparam int unsigned   CntW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] SlotLast  = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Held at zero while idle so every scan starts on a fresh slot.
    always_comb begin
        if (!enable_i || !run_i || (cnt_q == SlotLast)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign slot_done_o  = run_i && (cnt_q == SlotLast);
    assign blank_done_o = run_i && (BLANK_CYCLES != 0) && (cnt_q == BlankLast);

endmodule

// File: rtl/matrix_scan_controller.sv
// Column-multiplexed 5x7 LED matrix driver with blanking and frame-aligned
// double-buffered pattern loading.
module matrix_scan_controller
    import matrix_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          COL_ACTIVE_LOW = 1'b1,
    parameter bit          ROW_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [NUM_ROWS-1:0] col1_in,
    input  logic [NUM_ROWS-1:0] col2_in,
    input  logic [NUM_ROWS-1:0] col3_in,
    input  logic [NUM_ROWS-1:0] col4_in,
    input  logic [NUM_ROWS-1:0] col5_in,
    output logic [NUM_COLS-1:0] col_sel,
    output logic [NUM_ROWS-1:0] row_out,
    output logic                frame_done
);

    scan_state_t                 state_q, state_d;
    col_idx_t                    col_idx_q, col_idx_d;
    col_pattern_t [NUM_COLS-1:0] active_q, active_d;
    col_pattern_t [NUM_COLS-1:0] pending_q, pending_d;
    logic                        pend_flag_q, pend_flag_d;

    logic blank_done, slot_done;
    logic xfer, swap, frame_wrap;

    scan_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan_timer (
        .clk_i        (clk),
        .reset_i      (reset),
        .enable_i     (enable),
        .run_i        (state_q != IDLE),
        .blank_done_o (blank_done),
        .slot_done_o  (slot_done)
    );

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        if (!enable) begin
            state_d   = IDLE;
            col_idx_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    col_idx_d = '0;
                    state_d   = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
                end
                BLANK: begin
                    if (blank_done) begin
                        state_d = DRIVE;
                    end
                end
                DRIVE: begin
                    if (slot_done) begin
                        col_idx_d = (col_idx_q == LAST_COL) ? '0 : col_idx_q + 1'b1;
                        state_d   = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Swap only from an already-pending buffer, so a load accepted on the
    // boundary cycle waits a full frame.
    always_comb begin
        load_ready  = !pend_flag_q;
        xfer        = load_valid && !pend_flag_q;
        frame_wrap  = enable && (state_q == DRIVE) && slot_done && (col_idx_q == LAST_COL);
        swap        = pend_flag_q && ((state_q == IDLE) || frame_wrap);

        active_d    = swap ? pending_q : active_q;
        pending_d   = xfer ? {col5_in, col4_in, col3_in, col2_in, col1_in} : pending_q;
        pend_flag_d = pend_flag_q;
        if (xfer) begin
            pend_flag_d = 1'b1;
        end else if (swap) begin
            pend_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            col_idx_q   <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_flag_q <= pend_flag_d;
        end
    end

    logic [NUM_COLS-1:0] col_on;
    logic [NUM_ROWS-1:0] row_on;

    always_comb begin
        col_on = '0;
        row_on = '0;
        if (state_q == DRIVE) begin
            col_on = col_onehot(col_idx_q);
            row_on = active_q[col_idx_q];
        end
        col_sel = COL_ACTIVE_LOW ? ~col_on : col_on;
        row_out = ROW_ACTIVE_LOW ? ~row_on : row_on;
    end

    assign frame_done = (state_q == DRIVE) && slot_done && (col_idx_q == LAST_COL);

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Scoreboard bench for matrix_scan_controller with CLK_DIV=8, BLANK_CYCLES=2.
module tb_matrix_scan_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       load_valid = 1'b0;
    logic [6:0] c1 = '0, c2 = '0, c3 = '0, c4 = '0, c5 = '0;
    logic       load_ready, frame_done;
    logic [4:0] col_sel;
    logic [6:0] row_out;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int last_fd = 0;
    int fd_count = 0;

    typedef struct {
        int              cyc;
        logic [8*12-1:0] tag;
        logic [4:0]      col;
        logic [6:0]      row;
        logic            rdy;
        logic            fd;
    } exp_t;

    exp_t sb[$];

    matrix_scan_controller #(
        .CLK_DIV        (8),
        .BLANK_CYCLES   (2),
        .COL_ACTIVE_LOW (1'b1),
        .ROW_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .col1_in    (c1),
        .col2_in    (c2),
        .col3_in    (c3),
        .col4_in    (c4),
        .col5_in    (c5),
        .col_sel    (col_sel),
        .row_out    (row_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_at(input int n, input logic [8*12-1:0] tag, input logic [4:0] col,
                          input logic [6:0] row, input logic rdy, input logic fd);
        exp_t e;
        e.cyc = n;
        e.tag = tag;
        e.col = col;
        e.row = row;
        e.rdy = rdy;
        e.fd  = fd;
        sb.push_back(e);
    endtask

    task automatic set_pat(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                           input logic [6:0] d, input logic [6:0] e);
        c1 = a;
        c2 = b;
        c3 = c;
        c4 = d;
        c5 = e;
    endtask

    // Monitor: compare every scheduled expectation on the falling edge of its cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if ({col_sel, row_out, load_ready, frame_done} !==
                    {sb[i].col, sb[i].row, sb[i].rdy, sb[i].fd}) begin
                    errors++;
                    $display("FAIL %0s cyc %0d: got col_sel=%b row_out=%b load_ready=%b frame_done=%b, want col_sel=%b row_out=%b load_ready=%b frame_done=%b",
                             sb[i].tag, cyc, col_sel, row_out, load_ready, frame_done,
                             sb[i].col, sb[i].row, sb[i].rdy, sb[i].fd);
                end
                sb.delete(i);
            end
        end
        if (frame_done === 1'b1 && cyc <= 180) begin
            if (last_fd > 0) begin
                checks++;
                if (cyc - last_fd != 40) begin
                    errors++;
                    $display("FAIL fd_period cyc %0d: got %0d cycles, want 40", cyc, cyc - last_fd);
                end
            end
            last_fd = cyc;
            fd_count++;
        end
    end

    initial begin
        goto(2);
        reset = 1'b0;
        exp_at(2, "reset", 5'h1F, 7'h7F, 1'b1, 1'b0);
        exp_at(3, "idle", 5'h1F, 7'h7F, 1'b1, 1'b0);

        // Pattern A loaded together with enable: first frame dark, A from frame 2.
        goto(4);
        enable = 1'b1;
        load_valid = 1'b1;
        set_pat(7'b0111100, 7'b0011101, 7'b0110101, 7'b1000111, 7'b1110111);
        exp_at(4, "idle_load", 5'h1F, 7'h7F, 1'b1, 1'b0);
        exp_at(5, "blank_c0", 5'h1F, 7'h7F, 1'b0, 1'b0);
        exp_at(7, "dark_c0", 5'h1E, 7'h7F, 1'b0, 1'b0);
        exp_at(43, "pre_fd", 5'h0F, 7'h7F, 1'b0, 1'b0);
        exp_at(44, "fd1", 5'h0F, 7'h7F, 1'b0, 1'b1);
        exp_at(45, "swap_blank", 5'h1F, 7'h7F, 1'b1, 1'b0);
        exp_at(46, "blank2", 5'h1F, 7'h7F, 1'b1, 1'b0);
        exp_at(47, "a_c0_first", 5'h1E, 7'b1000011, 1'b1, 1'b0);
        exp_at(52, "a_c0_last", 5'h1E, 7'b1000011, 1'b1, 1'b0);
        exp_at(53, "c1_blank", 5'h1F, 7'h7F, 1'b1, 1'b0);
        exp_at(79, "a_c4_first", 5'h0F, 7'b0001000, 1'b1, 1'b0);
        exp_at(84, "fd2", 5'h0F, 7'b0001000, 1'b1, 1'b1);
        exp_at(85, "f3_blank", 5'h1F, 7'h7F, 1'b1, 1'b0);
        goto(5);
        load_valid = 1'b0;

        // B mid-frame, then C held until accepted on boundary+1.
        goto(93);
        load_valid = 1'b1;
        set_pat(7'h01, 7'h02, 7'h04, 7'h08, 7'h10);
        exp_at(93, "b_offer", 5'h1F, 7'h7F, 1'b1, 1'b0);
        exp_at(94, "b_held", 5'h1F, 7'h7F, 1'b0, 1'b0);
        exp_at(124, "fd3_hold", 5'h0F, 7'b0001000, 1'b0, 1'b1);
        exp_at(125, "c_accept", 5'h1F, 7'h7F, 1'b1, 1'b0);
        exp_at(126, "c_held", 5'h1F, 7'h7F, 1'b0, 1'b0);
        exp_at(127, "b_c0", 5'h1E, 7'h7E, 1'b0, 1'b0);
        exp_at(159, "b_c4", 5'h0F, 7'h6F, 1'b0, 1'b0);
        exp_at(164, "fd4", 5'h0F, 7'h6F, 1'b0, 1'b1);
        exp_at(165, "c_swap", 5'h1F, 7'h7F, 1'b1, 1'b0);
        exp_at(167, "c_c0", 5'h1E, 7'h00, 1'b1, 1'b0);
        goto(94);
        set_pat(7'h7F, 7'h55, 7'h2A, 7'h00, 7'h40);
        goto(126);
        load_valid = 1'b0;

        // Drop enable on the third DRIVE cycle of column 2, then restart.
        goto(185);
        enable = 1'b0;
        exp_at(185, "c_c2_drv3", 5'h1B, 7'h55, 1'b1, 1'b0);
        exp_at(186, "dis_idle", 5'h1F, 7'h7F, 1'b1, 1'b0);
        exp_at(187, "dis_idle2", 5'h1F, 7'h7F, 1'b1, 1'b0);
        goto(188);
        enable = 1'b1;
        exp_at(188, "reen_idle", 5'h1F, 7'h7F, 1'b1, 1'b0);
        exp_at(189, "reen_blank", 5'h1F, 7'h7F, 1'b1, 1'b0);
        exp_at(191, "reen_c0", 5'h1E, 7'h00, 1'b1, 1'b0);

        // Reset during DRIVE with a load pending: everything cleared.
        goto(192);
        load_valid = 1'b1;
        set_pat(7'h11, 7'h11, 7'h11, 7'h11, 7'h11);
        exp_at(192, "d_offer", 5'h1E, 7'h00, 1'b1, 1'b0);
        exp_at(193, "d_pend", 5'h1E, 7'h00, 1'b0, 1'b0);
        goto(193);
        load_valid = 1'b0;
        goto(194);
        reset = 1'b1;
        enable = 1'b0;
        exp_at(194, "pre_rst", 5'h1E, 7'h00, 1'b0, 1'b0);
        exp_at(195, "rst_mid", 5'h1F, 7'h7F, 1'b1, 1'b0);
        goto(195);
        reset = 1'b0;
        enable = 1'b1;
        exp_at(198, "dark_c0b", 5'h1E, 7'h7F, 1'b1, 1'b0);
        exp_at(235, "dark_fd", 5'h0F, 7'h7F, 1'b1, 1'b1);
        exp_at(238, "dark_next", 5'h1E, 7'h7F, 1'b1, 1'b0);

        goto(240);
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %0s: got no sample at cyc %0d, want a compare", sb[0].tag, sb[0].cyc);
            void'(sb.pop_front());
        end
        checks++;
        if (fd_count != 4) begin
            errors++;
            $display("FAIL fd_count: got %0d pulses, want 4", fd_count);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
